pci_target_responder: RTL and testbench

PCI_TARGET_RESPONDER -- requirements
Module: pci_target_responder

---
 rtl/pci_pkg.sv | 17 +
 rtl/pci_tgt_mem.sv | 35 +++
 rtl/pci_target_responder.sv | 145 ++++++++++++++
 tb/tb_pci_target_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared PCI definitions: target FSM state encodings and cbe command constants.
// Used by the target responder, the arbiter and the device model.
package pci_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TURN  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } pci_state_t;

  localparam logic CBE_READ  = 1'b1;
  localparam logic CBE_WRITE = 1'b0;

endpackage

// File: rtl/pci_tgt_mem.sv
// PCI target word memory: async reset loads INIT_WORD everywhere,
// one synchronous write port, one combinational read port.
module pci_tgt_mem #(
  parameter int          DEPTH     = 16,
  parameter int          AW        = $clog2(DEPTH),
  parameter logic [31:0] INIT_WORD = 32'hBBBBBBBB
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_WORD;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pci_target_responder.sv
// PCI target: claims DEVICE_ID window, bursts to/from pci_tgt_mem.
// Define PCI_TGT_WAIT_EN to insert one WAIT cycle before the first data phase.
module pci_target_responder
  import pci_pkg::*;
#(
  parameter logic [31:0] DEVICE_ID = 32'h00000001,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] INIT_WORD = 32'hBBBBBBBB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame,
  input  logic        i_ready,
  input  logic        cbe,
  input  logic [31:0] ad_in,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        t_ready,
  output logic        devSelect,
  output logic        targetflag,
  output logic        target_found
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] IDX_ONE = 1;

  pci_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   ad_out_q, ad_out_d;
  logic          rd_q, rd_d;
  logic          frame_q;

  logic          addr_phase;
  logic          hit;
  logic          data_st;
  logic          we;
  logic [AW-1:0] idx_inc;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;

  assign addr_phase = frame_q & ~frame;
  assign hit     = (ad_in[31:AW] == DEVICE_ID[31:AW]);
  assign idx_inc = idx_q + IDX_ONE;
  assign data_st = (state_q == ST_WDATA) || (state_q == ST_RDATA);
  // Read port looks one word ahead on a completed transfer.
  assign raddr   = (data_st && !i_ready) ? idx_inc : idx_q;

  pci_tgt_mem #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .INIT_WORD(INIT_WORD)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .waddr(idx_q),
    .wdata(ad_in),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ad_out_d   = ad_out_q;
    rd_d       = rd_q;
    we         = 1'b0;
    t_ready    = 1'b1;
    devSelect  = 1'b1;
    ad_oe      = 1'b0;
    targetflag = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (addr_phase && hit) begin
          idx_d = ad_in[AW-1:0];
          rd_d  = (cbe == CBE_READ);
          if (cbe == CBE_READ) begin
            state_d = ST_TURN;
          end else begin
`ifdef PCI_TGT_WAIT_EN
            state_d = ST_WAIT;
`else
            state_d = ST_WDATA;
`endif
          end
        end
      end
      ST_TURN: begin
        targetflag = 1'b1;
        devSelect  = 1'b0;
        ad_out_d   = rdata;
`ifdef PCI_TGT_WAIT_EN
        state_d = ST_WAIT;
`else
        state_d = ST_RDATA;
`endif
      end
      ST_WAIT: begin
        targetflag = 1'b1;
        devSelect  = 1'b0;
        ad_oe      = rd_q;
        state_d    = rd_q ? ST_RDATA : ST_WDATA;
      end
      ST_WDATA, ST_RDATA: begin
        targetflag = 1'b1;
        devSelect  = 1'b0;
        t_ready    = 1'b0;
        ad_oe      = (state_q == ST_RDATA);
        if (!i_ready) begin
          idx_d = idx_inc;
          we    = (state_q == ST_WDATA);
          if (state_q == ST_RDATA) ad_out_d = rdata;
          if (frame) state_d = ST_DONE;
        end else if (frame) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        targetflag = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      ad_out_q <= '0;
      rd_q     <= 1'b0;
      frame_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ad_out_q <= ad_out_d;
      rd_q     <= rd_d;
      frame_q  <= frame;
    end
  end

  assign ad_out       = ad_out_q;
  assign target_found = targetflag;

endmodule

// File: tb/tb_pci_target_responder.sv
// Randomized self-checking bench for pci_target_responder against a
// transaction-level model (word array + protocol latency rules).
module tb_pci_target_responder;

  localparam logic [31:0] DEV  = 32'h00000001;
  localparam logic [31:0] INIT = 32'hBBBBBBBB;
  localparam int          DEP  = 16;
`ifdef PCI_TGT_WAIT_EN
  localparam int WAITC = 1;
`else
  localparam int WAITC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        frame;
  logic        i_ready;
  logic        cbe;
  logic [31:0] ad_in;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        t_ready;
  logic        devSelect;
  logic        targetflag;
  logic        target_found;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [DEP];
  logic [31:0] wdat [8];
  logic [31:0] base;

  pci_target_responder #(
    .DEVICE_ID(DEV),
    .DEPTH    (DEP),
    .INIT_WORD(INIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame       (frame),
    .i_ready     (i_ready),
    .cbe         (cbe),
    .ad_in       (ad_in),
    .ad_out      (ad_out),
    .ad_oe       (ad_oe),
    .t_ready     (t_ready),
    .devSelect   (devSelect),
    .targetflag  (targetflag),
    .target_found(target_found)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < DEP; i++) mdl[i] = INIT;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_tf"}, 32'(targetflag), 0);
    chk({tag, "_fnd"}, 32'(target_found), 0);
    chk({tag, "_oe"}, 32'(ad_oe), 0);
    chk({tag, "_trdy"}, 32'(t_ready), 1);
    chk({tag, "_dsel"}, 32'(devSelect), 1);
    chk({tag, "_ad"}, ad_out, 0);
  endtask

  task automatic chk_data(input bit rd, input int idx);
    chk("dat_trdy", 32'(t_ready), 0);
    chk("dat_dsel", 32'(devSelect), 0);
    chk("dat_tf", 32'(targetflag), 1);
    chk("dat_oe", 32'(ad_oe), 32'(rd));
    if (rd) chk("dat_ad", ad_out, mdl[idx]);
  endtask

  // One bus transaction. st<0: random stalls per phase; st>=0: that many
  // stall cycles before the second phase. abort: last phase is a master abort.
  // ign: address phase presented while the target is in DONE.
  task automatic xfer(input bit rd, input logic [31:0] addr, input int n,
                      input int st, input bit abort, input bit ign);
    bit hit;
    int idx;
    int s;
    hit = ((addr >> 4) == (DEV >> 4));
    idx = int'(addr % DEP);
    frame = 1'b0; i_ready = 1'b1; cbe = rd; ad_in = addr;
    tick();
    if (!hit) begin
      repeat (n + 2) begin
        chk("miss_tf", 32'(targetflag), 0);
        chk("miss_fnd", 32'(target_found), 0);
        chk("miss_oe", 32'(ad_oe), 0);
        chk("miss_dsel", 32'(devSelect), 1);
        ad_in = $urandom; i_ready = 1'b0;
        tick();
      end
      frame = 1'b1; i_ready = 1'b1;
      tick();
      chk("miss_end_tf", 32'(targetflag), 0);
      return;
    end
    for (int j = 0; j < (rd ? 1 : 0) + WAITC; j++) begin
      chk("lat_trdy", 32'(t_ready), 1);
      chk("lat_dsel", 32'(devSelect), 0);
      chk("lat_tf", 32'(targetflag), 1);
      chk("lat_oe", 32'(ad_oe), 32'(rd && j == 1));
      tick();
    end
    for (int k = 0; k < n; k++) begin
      s = (st < 0) ? int'($urandom_range(0, 2)) : ((k == 1) ? st : 0);
      repeat (s) begin
        chk_data(rd, idx);
        i_ready = 1'b1; frame = 1'b0; ad_in = $urandom;
        tick();
      end
      chk_data(rd, idx);
      if (abort && k == n - 1) begin
        i_ready = 1'b1; frame = 1'b1; ad_in = $urandom;
        tick();
      end else begin
        i_ready = 1'b0; frame = (k == n - 1); ad_in = wdat[k];
        tick();
        if (!rd) mdl[idx] = wdat[k];
        idx = (idx + 1) % DEP;
      end
    end
    chk("done_tf", 32'(targetflag), 1);
    chk("done_fnd", 32'(target_found), 1);
    chk("done_trdy", 32'(t_ready), 1);
    chk("done_dsel", 32'(devSelect), 1);
    chk("done_oe", 32'(ad_oe), 0);
    i_ready = 1'b1;
    if (ign) begin
      frame = 1'b0; cbe = rd; ad_in = addr;
      tick();
      chk("ign_tf", 32'(targetflag), 0);
      tick();
      chk("ign_tf2", 32'(targetflag), 0);
      frame = 1'b1;
      tick();
    end else begin
      frame = 1'b1;
      tick();
    end
    chk("idle_tf", 32'(targetflag), 0);
    chk("idle_fnd", 32'(target_found), 0);
  endtask

  task automatic rdall();
    xfer(1'b1, base, DEP, 0, 1'b0, 1'b0);
  endtask

  initial begin
    bit rd;
    int n;
    logic [31:0] a;
    base = DEV & ~32'(DEP - 1);
    reset = 1'b0; frame = 1'b1; i_ready = 1'b1; cbe = 1'b0; ad_in = '0;
    mdl_reset();
    tick();
    tick();
    chk_rst("rst");
    reset = 1'b1;
    tick();

    xfer(1'b1, 32'h00000000, 2, 0, 1'b0, 1'b0);

    wdat[0] = 32'd11; wdat[1] = 32'd22; wdat[2] = 32'd33;
    xfer(1'b0, 32'h00000003, 3, 0, 1'b0, 1'b0);
    xfer(1'b1, 32'h00000003, 3, 0, 1'b0, 1'b0);
    chk("mem3", mdl[3], 32'd11);
    chk("mem5", mdl[5], 32'd33);

    wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC;
    xfer(1'b0, base | 32'd15, 3, 0, 1'b0, 1'b0);
    xfer(1'b1, base | 32'd15, 3, 0, 1'b0, 1'b0);
    chk("wrap0", mdl[0], 32'hB);

    xfer(1'b0, 32'h12345678, 3, 0, 1'b0, 1'b0);

    wdat[0] = 32'h1111_0008; wdat[1] = 32'h2222_0009; wdat[2] = 32'h3333_000A;
    xfer(1'b0, base | 32'd8, 3, 2, 1'b0, 1'b0);
    xfer(1'b1, base | 32'd8, 3, 2, 1'b0, 1'b0);

    frame = 1'b0; i_ready = 1'b1; cbe = 1'b0; ad_in = base | 32'd6;
    tick();
    repeat (WAITC) tick();
    i_ready = 1'b0; ad_in = 32'hDEAD_0006;
    tick();
    i_ready = 1'b1; ad_in = 32'hDEAD_0007;
    tick();
    reset = 1'b0;
    #1;
    chk_rst("midrst");
    mdl_reset();
    frame = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    rdall();

    repeat (30) begin
      rd = 1'($urandom);
      n  = int'($urandom_range(1, 5));
      a  = ($urandom_range(0, 7) == 0) ? $urandom : (base | $urandom_range(0, 15));
      for (int i = 0; i < 8; i++) wdat[i] = $urandom;
      xfer(rd, a, n, -1, (n > 1) && ($urandom_range(0, 5) == 0),
           $urandom_range(0, 3) == 0);
    end
    rdall();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
